// File: rtl/muldiv_sequencer_if.sv
// Request/result bundle between a requester and the multiply/divide sequencer.
interface muldiv_sequencer_if;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        divby0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        hiwrite;
  logic        lowrite;

  modport master (
    output start, op, a, b,
    input  busy, done, divby0, hi, lo, hiwrite, lowrite
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, divby0, hi, lo, hiwrite, lowrite
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative 32-bit signed multiply / divide sequencer producing HI/LO words.
// Operands are reduced to magnitudes on start, processed one bit per cycle
// for 32 cycles, and sign-corrected in a single FINISH cycle.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; hi/lo hold last written result
// MULT   | unsigned shift-add on magnitudes, one multiplier bit per cycle
// DIV    | restoring division on magnitudes, one quotient bit per cycle
// FINISH | sign correction, hi/lo update, done/write strobes (or divby0)
module muldiv_sequencer (
  input  logic              clk,
  input  logic              reset,
  muldiv_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    DIV    = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  // opnd holds the multiplicand (mult) or divisor (div) magnitude.
  logic [31:0] opnd;
  // acc_hi/acc_lo: partial product during mult; remainder/quotient during div.
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;
  logic        res_neg;
  logic        rem_neg;
  logic        op_div;
  logic        div_zero;

  logic        busy_q;
  logic        done_q;
  logic        divby0_q;
  logic        hiwrite_q;
  logic        lowrite_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        b_zero;
  logic        iter_last;
  logic [32:0] mult_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic        div_ge;
  logic [63:0] prod_raw;
  logic [63:0] prod_signed;
  logic [31:0] quot_signed;
  logic [31:0] rem_signed;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude 2^31.
  assign a_mag  = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
  assign b_mag  = bus.b[31] ? (~bus.b + 32'd1) : bus.b;
  assign b_zero = (bus.b == 32'd0);

  assign iter_last = (cnt == 6'd31);

  // Shift-add step: add multiplicand when the current multiplier LSB is set,
  // then shift the 65-bit {carry, acc_hi, acc_lo} right by one.
  assign mult_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);

  // Restoring step: shift the next dividend bit into the remainder and try
  // to subtract the divisor; keep the difference only if it did not go negative.
  assign div_shift = {acc_hi, acc_lo[31]};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign div_diff  = div_shift - {1'b0, opnd};

  assign prod_raw    = {acc_hi, acc_lo};
  assign prod_signed = res_neg ? (~prod_raw + 64'd1) : prod_raw;
  assign quot_signed = res_neg ? (~acc_lo + 32'd1) : acc_lo;
  assign rem_signed  = rem_neg ? (~acc_hi + 32'd1) : acc_hi;

  // Sequencer state, datapath iteration and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 6'd0;
      opnd      <= 32'd0;
      acc_hi    <= 32'd0;
      acc_lo    <= 32'd0;
      res_neg   <= 1'b0;
      rem_neg   <= 1'b0;
      op_div    <= 1'b0;
      div_zero  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divby0_q  <= 1'b0;
      hiwrite_q <= 1'b0;
      lowrite_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      done_q    <= 1'b0;
      divby0_q  <= 1'b0;
      hiwrite_q <= 1'b0;
      lowrite_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            opnd     <= bus.op ? b_mag : a_mag;
            acc_hi   <= 32'd0;
            acc_lo   <= bus.op ? a_mag : b_mag;
            cnt      <= 6'd0;
            res_neg  <= bus.a[31] ^ bus.b[31];
            rem_neg  <= bus.a[31];
            op_div   <= bus.op;
            div_zero <= bus.op & b_zero;
            busy_q   <= 1'b1;
            if (!bus.op)
              state <= MULT;
            else if (!b_zero)
              state <= DIV;
            else
              state <= FINISH;
          end
        end
        MULT: begin
          acc_hi <= mult_sum[32:1];
          acc_lo <= {mult_sum[0], acc_lo[31:1]};
          cnt    <= cnt + 6'd1;
          if (iter_last)
            state <= FINISH;
        end
        DIV: begin
          if (div_ge) begin
            acc_hi <= div_diff[31:0];
            acc_lo <= {acc_lo[30:0], 1'b1};
          end else begin
            acc_hi <= div_shift[31:0];
            acc_lo <= {acc_lo[30:0], 1'b0};
          end
          cnt <= cnt + 6'd1;
          if (iter_last)
            state <= FINISH;
        end
        FINISH: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= IDLE;
          if (div_zero) begin
            // No valid result: hi/lo are left untouched and no write strobes.
            divby0_q <= 1'b1;
          end else begin
            hiwrite_q <= 1'b1;
            lowrite_q <= 1'b1;
            if (op_div) begin
              hi_q <= rem_signed;
              lo_q <= quot_signed;
            end else begin
              hi_q <= prod_signed[63:32];
              lo_q <= prod_signed[31:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.divby0  = divby0_q;
  assign bus.hiwrite = hiwrite_q;
  assign bus.lowrite = lowrite_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table plus multi-cycle sequences.
module tb_muldiv_sequencer;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   lat;

  muldiv_sequencer_if bus ();

  muldiv_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs [14];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after the edge that samples start.
  task automatic start_op(input logic op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 1;
  endtask

  // Advances until done is seen (bounded); lat counts edges since the start edge.
  task automatic wait_done();
    while (!bus.done && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[2]  = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[4]  = '{1'b1, 32'h00000005, 32'h00000000, 32'h00000001, 32'h23456780, 1'b1};
    vecs[5]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[6]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
    vecs[9]  = '{1'b1, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    vecs[10] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0};
    vecs[11] = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
    vecs[12] = '{1'b1, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[13] = '{1'b0, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0};

    tests = 0;
    fails = 0;
    lat   = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("rst_busy",    {63'd0, bus.busy},    64'd0);
    chk("rst_done",    {63'd0, bus.done},    64'd0);
    chk("rst_divby0",  {63'd0, bus.divby0},  64'd0);
    chk("rst_hiwrite", {63'd0, bus.hiwrite}, 64'd0);
    chk("rst_lowrite", {63'd0, bus.lowrite}, 64'd0);
    chk("rst_hilo",    {bus.hi, bus.lo},     64'd0);

    // Vector table: each op run to completion with latency and strobes checked.
    for (int i = 0; i < 14; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_busy", i), {63'd0, bus.busy}, 64'd1);
      wait_done();
      chk($sformatf("v%0d_latency", i), 64'(lat), vecs[i].dz ? 64'd2 : 64'd34);
      chk($sformatf("v%0d_done", i), {63'd0, bus.done}, 64'd1);
      chk($sformatf("v%0d_busy_end", i), {63'd0, bus.busy}, 64'd0);
      chk($sformatf("v%0d_divby0", i), {63'd0, bus.divby0}, {63'd0, vecs[i].dz});
      chk($sformatf("v%0d_writes", i), {62'd0, bus.hiwrite, bus.lowrite},
          vecs[i].dz ? 64'd0 : 64'd3);
      chk($sformatf("v%0d_hi", i), {32'd0, bus.hi}, {32'd0, vecs[i].hi});
      chk($sformatf("v%0d_lo", i), {32'd0, bus.lo}, {32'd0, vecs[i].lo});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pulse", i), {61'd0, bus.done, bus.hiwrite, bus.lowrite}, 64'd0);
      chk($sformatf("v%0d_hold", i), {bus.hi, bus.lo}, {vecs[i].hi, vecs[i].lo});
    end

    // start while busy is ignored: mult 3*4, div 9/2 offered at cycle 10.
    start_op(1'b0, 32'd3, 32'd4);
    while (lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start = 1'b1;
    bus.op    = 1'b1;
    bus.a     = 32'd9;
    bus.b     = 32'd2;
    @(posedge clk);
    #1;
    lat++;
    bus.start = 1'b0;
    wait_done();
    chk("busy_ign_latency", 64'(lat), 64'd34);
    chk("busy_ign_result", {bus.hi, bus.lo}, 64'd12);
    @(posedge clk);
    #1;
    chk("busy_ign_idle", {62'd0, bus.busy, bus.done}, 64'd0);

    // Reset mid-operation aborts with no done, then a fresh mult works.
    start_op(1'b0, 32'h12345678, 32'h9ABCDEF0);
    while (lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_flags", {59'd0, bus.busy, bus.done, bus.divby0, bus.hiwrite, bus.lowrite}, 64'd0);
    chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk);
        #1;
        if (bus.done || bus.hiwrite || bus.lowrite || bus.busy) seen = 1'b1;
      end
      chk("abort_no_done", {63'd0, seen}, 64'd0);
    end
    start_op(1'b0, 32'h80000000, 32'h80000000);
    wait_done();
    chk("post_abort_latency", 64'(lat), 64'd34);
    chk("post_abort_result", {bus.hi, bus.lo}, 64'h40000000_00000000);

    // Back-to-back: new start accepted in the done cycle.
    @(posedge clk);
    #1;
    start_op(1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_done();
    chk("b2b_div_latency", 64'(lat), 64'd34);
    chk("b2b_div_result", {bus.hi, bus.lo}, 64'h00000000_80000000);
    chk("b2b_div_divby0", {63'd0, bus.divby0}, 64'd0);
    start_op(1'b0, 32'd2, 32'd3);
    chk("b2b_mult_busy", {63'd0, bus.busy}, 64'd1);
    wait_done();
    chk("b2b_mult_latency", 64'(lat), 64'd34);
    chk("b2b_mult_result", {bus.hi, bus.lo}, 64'd6);
    chk("b2b_mult_writes", {62'd0, bus.hiwrite, bus.lowrite}, 64'd3);

    // Reset has priority over a simultaneous start.
    @(posedge clk);
    #1;
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 32'd5;
    bus.b     = 32'd5;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    bus.start = 1'b0;
    chk("rst_prio_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_prio_hilo", {bus.hi, bus.lo}, 64'd0);
    repeat (36) @(posedge clk);
    #1;
    chk("rst_prio_no_op", {62'd0, bus.busy, bus.done}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameters: none; operand and result widths SHALL be fixed at 32 bits.
REQ-002 clk  input  1  clock; all state SHALL change on the rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; SHALL be sampled only in IDLE.
REQ-005 op  input  1  0 = signed multiply (mult), 1 = signed divide (div).
REQ-006 a  input  32  rs operand (multiplicand / dividend); sampled with start.
REQ-007 b  input  32  rt operand (multiplier / divisor); sampled with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 divby0  output  1  one-cycle pulse, coincident with done, for div with b == 0.
REQ-011 hi  output  32  mult: upper product word; div: remainder.
REQ-012 lo  output  32  mult: lower product word; div: quotient.
REQ-013 hiwrite, lowrite  output  1 each  one-cycle write strobes to the HI/LO registers, coincident with done on valid results.

Function
REQ-014 FSM states SHALL be IDLE, MULT, DIV and FINISH.
REQ-015 IDLE -> MULT on start & !op; IDLE -> DIV on start & op & b != 0; IDLE -> FINISH on start & op & b == 0.
REQ-016 The start edge SHALL latch |a|, |b|, the result sign (a[31]^b[31]), the dividend sign (a[31]) and clear the 6-bit iteration counter.
REQ-017 MULT SHALL perform unsigned shift-add on the magnitudes, one bit per cycle, for exactly 32 cycles, then move to FINISH.
REQ-018 DIV SHALL perform restoring division on the magnitudes, one quotient bit per cycle, for exactly 32 cycles, then move to FINISH.
REQ-019 FINISH SHALL apply sign correction, register hi/lo, pulse done, hiwrite and lowrite for one cycle, and return to IDLE in one cycle.
REQ-020 Sign rule for mult: the 64-bit product SHALL be negated when the result sign is 1.
REQ-021 Sign rule for div: the quotient SHALL truncate toward zero (negated when the result sign is 1); the remainder SHALL take the sign of the dividend.
REQ-022 Arithmetic SHALL wrap modulo 2^32 per word.
REQ-023 0x80000000 * 0x80000000 SHALL give hi=0x40000000, lo=0x00000000.
REQ-024 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000, with no divby0.
REQ-025 Timing: if start is sampled at edge E0, busy SHALL be high from after E0 through edge E33.
REQ-026 Timing: done, hiwrite and lowrite SHALL be high in the single cycle following E33 (34-cycle latency).
REQ-027 Divide-by-zero: divby0 and done SHALL be high in the cycle following E1, with hiwrite=lowrite=0 and hi/lo unchanged.
REQ-028 start while busy SHALL be ignored, with no effect on the operation in progress.
REQ-029 start in the cycle in which done is high SHALL be accepted, because the FSM is already in IDLE.
REQ-030 hi/lo SHALL hold their last values between operations.

Reset
REQ-031 On reset, the FSM SHALL enter IDLE, and busy, done, divby0, hiwrite and lowrite SHALL be 0.
REQ-032 On reset, hi and lo SHALL be 0x00000000, and the counter and internal accumulators SHALL be cleared.
REQ-033 Reset mid-operation SHALL abort the operation with no done or write strobe.
REQ-034 reset SHALL take priority over start in the same cycle.

Verification
REQ-035 mult a=7, b=0xFFFFFFFD (-3) -> after 34 cycles: hi=0xFFFFFFFF, lo=0xFFFFFFEB, done=hiwrite=lowrite=1 for one cycle.
REQ-036 div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; div a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
REQ-037 div a=5, b=0 with prior hi=lo=0x12345678 -> done=divby0=1 at cycle 2, hiwrite=lowrite=0, hi/lo remain 0x12345678.
REQ-038 mult 3*4, then start div 9/2 at cycle 10 -> div is ignored; hi=0, lo=12 at cycle 34; busy=0 afterwards.
REQ-039 mult started, reset asserted at iteration 10 -> all outputs 0 and no done; then mult 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
REQ-040 Back-to-back: div 0x80000000/0xFFFFFFFF, with start re-asserted on the done cycle for mult 2*3 -> lo=0x80000000, hi=0, then hi=0, lo=6 exactly 34 cycles later.
